icache_direct: RTL and testbench
================================

# icache_direct

Direct-mapped, one-word-block instruction cache between the pipelined datapath's fetch stage and the memory controller. Serves `imemload`/`ihit` for the datapath's instruction port. On a miss it runs a one-request fill from memory, writes the frame, and retries. Hits return the instruction in the same cycle as the request, so the PC advances without stalling.

## Interface
Parameters:
- `SETS`, default 16: number of frames. Power of two, at least 2. `IDX_W = log2(SETS)`.
- `PC_BITS`, default 32: address and data width (`word_t`).

Ports:
- `CLK`, input, 1: rising-edge clock. Sole clock.
- `nRST`, input, 1: reset. Synchronous and active-high: sampled on the rising edge of `CLK`, and a value of 1 resets.
- `imemREN`, input, 1: datapath instruction read request.
- `imemaddr`, input, 32: datapath byte address. Bits [1:0] are ignored.
- `ihit`, output, 1: requested instruction is valid on `imemload` this cycle.
- `imemload`, output, 32: instruction data.
- `iREN`, output, 1: read request to the memory controller.
- `iaddr`, output, 32: fill address, word-aligned.
- `iwait`, input, 1: memory busy. A cycle with `iREN`=1 and `iwait`=0 completes the read.
- `iload`, input, 32: memory read data, valid when `iwait`=0.

## Operation
- Address split: index = `imemaddr[IDX_W+1:2]`, tag = `imemaddr[31:IDX_W+2]`.
- Each frame holds `valid` (1 bit), `tag` (`32-IDX_W-2` bits) and `data` (32 bits).
- `hit` = `imemREN` & `valid[idx]` & (`tag[idx]` == addr tag), decoded combinationally from `imemaddr`.
- The FSM has two states: IDLE and FILL.
- IDLE:
  - `ihit` = `hit`, and `imemload` = `data[idx]`.
  - If `imemREN` & !`hit`: latch `fill_addr` = {`imemaddr[31:2]`, 2'b00} and go to FILL.
  - Otherwise stay in IDLE.
- FILL:
  - Drive `iREN`=1 and `iaddr`=`fill_addr`. `ihit`=0.
  - When `iwait`=0: write `data`=`iload`, the tag of `fill_addr`, and `valid`=1 into frame index(`fill_addr`), then go to IDLE.
  - While `iwait`=1: stay in FILL and hold `iaddr` stable.
- The fill always runs to completion once started, even if `imemREN` drops or `imemaddr` changes mid-fill. The line is written and no fill is aborted.
- There is no fill-forward. The requester hits on the cycle after the write, provided its address still matches.
- `iREN`=0 and `iaddr`=0 in IDLE.
- There is no write port. Instruction memory is read-only to this block, and frames are invalidated only by reset.
- Replacement: a miss overwrites its frame unconditionally (direct-mapped). A conflicting tag evicts the old line.

## Timing
- On reset (nRST=1 at a clock edge):
  - All `valid` bits clear, state returns to IDLE, and `fill_addr` becomes 0.
  - Outputs: `ihit`=0, `iREN`=0, `iaddr`=0, `imemload`=`data[idx]` (its value is don't-care while `ihit`=0).
  - `data` and `tag` arrays need not be reset.
- Reset mid-FILL abandons the fill. `iREN` drops the cycle after the reset edge and nothing is written to the array.
- Hit latency: 0 cycles, combinational from `imemaddr`.
- Miss penalty: the miss is detected in cycle 0 and the block enters FILL at edge 1. With memory latency L (cycles with `iwait`=1, then one cycle with `iwait`=0), the frame is written at edge 2+L and `ihit` rises in cycle 2+L.
- Edge cases:
  - `imemREN`=0 in IDLE: `ihit`=0 and no state change.
  - Miss in IDLE with `iwait` already 0 in the first FILL cycle: the fill completes in one cycle (L=0).
  - Same index, different tag on back-to-back misses: each starts its own fill and the later fill overwrites the earlier one.
  - Reset and `iwait`=0 in the same cycle: reset wins and nothing is written.

## Test plan
- **Reset state:** hold nRST=1 for 2 edges, release, then request 0x00000000. Required: `ihit`=0 in the first cycle and `iREN`=1 with `iaddr`=0x00000000 in the next.
- **Cold miss then hit:** request 0x00000040 with memory returning 0x8C010004 after L=3. Required:
  - `iREN` is high for 4 cycles.
  - `ihit`=1 with `imemload`=0x8C010004 in the cycle after the fill.
  - Repeat requests hit with `iREN`=0.
- **Conflict eviction:** with SETS=16, fill 0x00000004 (data 0xAAAA0001), then request 0x00000044 (same index 1, data 0xBBBB0002). Required:
  - 0x44 misses and fills.
  - A subsequent request to 0x04 misses again (`iREN`=1, `iaddr`=0x00000004).
- **Address change mid-fill:** start a miss on 0x00000080, then switch `imemaddr` to 0x00000100 during `iwait`=1. Required:
  - `iaddr` stays at 0x00000080 until completion.
  - Frame 0 receives tag 0x2 and is valid.
  - A new fill for 0x100 starts afterwards.
- **Reset mid-fill:** assert nRST during FILL while `iwait`=1, then release. Required:
  - `iREN` is 0 the cycle after the reset edge.
  - A re-request of the same address misses (the frame was not written).
- **Byte-offset ignore:** after filling 0x00000010, request 0x00000013. Required: `ihit`=1 with the same data.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-block instruction cache for the datapath fetch port.
// Hits are combinational; misses run a single blocking fill from memory and retry.
module icache_direct #(
  parameter int SETS    = 16,
  parameter int PC_BITS = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               imemREN,
  input  logic [PC_BITS-1:0] imemaddr,
  output logic               ihit,
  output logic [PC_BITS-1:0] imemload,
  output logic               iREN,
  output logic [PC_BITS-1:0] iaddr,
  input  logic               iwait,
  input  logic [PC_BITS-1:0] iload
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = PC_BITS - IDX_W - 2;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t                         state, state_n;
  logic [PC_BITS-3:0]             fill_word, fill_word_n;
  logic [SETS-1:0]                valid;
  logic [SETS-1:0][TAG_W-1:0]     tag_arr;
  logic [SETS-1:0][PC_BITS-1:0]   data_arr;

  logic [IDX_W-1:0] idx, fidx;
  logic [TAG_W-1:0] tag, ftag;
  logic             hit, fill_done;
  logic             unused_byte_ofs;

  assign idx       = imemaddr[IDX_W+1:2];
  assign tag       = imemaddr[PC_BITS-1:IDX_W+2];
  assign fidx      = fill_word[IDX_W-1:0];
  assign ftag      = fill_word[PC_BITS-3:IDX_W];
  assign hit       = imemREN & valid[idx] & (tag_arr[idx] == tag);
  assign fill_done = (state == FILL) & ~iwait;
  assign unused_byte_ofs = ^imemaddr[1:0];

  // Reset blocks the write so a fill completing on the reset edge is dropped.
  always_ff @(posedge CLK) begin
    if (nRST)           valid       <= '0;
    else if (fill_done) valid[fidx] <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!nRST && fill_done) begin
      data_arr[fidx] <= iload;
      tag_arr[fidx]  <= ftag;
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state     <= IDLE;
      fill_word <= '0;
    end else begin
      state     <= state_n;
      fill_word <= fill_word_n;
    end
  end

  always_comb begin
    state_n     = state;
    fill_word_n = fill_word;
    ihit        = 1'b0;
    iREN        = 1'b0;
    iaddr       = '0;
    imemload    = data_arr[idx];
    case (state)
      IDLE: begin
        ihit = hit;
        if (imemREN && !hit) begin
          fill_word_n = imemaddr[PC_BITS-1:2];
          state_n     = FILL;
        end
      end
      FILL: begin
        // Fill address is latched, so the requester may wander without aborting.
        iREN  = 1'b1;
        iaddr = {fill_word, 2'b00};
        if (!iwait) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: expected fill data is queued when a miss is
// issued and popped when the cache reports the hit.
module tb_icache_direct;
  logic        CLK, nRST, imemREN, ihit, iREN, iwait;
  logic [31:0] imemaddr, imemload, iaddr, iload;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  icache_direct #(.SETS(16), .PC_BITS(32)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_hit(input string tag);
    logic [31:0] exp;
    #1;
    chk({tag, "_ihit"}, {31'd0, ihit}, 32'd1);
    chk({tag, "_iren"}, {31'd0, iREN}, 32'd0);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      exp = sb_q.pop_front();
      chk({tag, "_load"}, imemload, exp);
    end
  endtask

  // Memory side of a fill already in progress: L busy cycles then one ready.
  task automatic fill(input string tag, input logic [31:0] addr, input logic [31:0] data, input int lat);
    for (int i = 0; i < lat; i++) begin
      iwait = 1'b1;
      #1;
      chk({tag, "_busy_iren"}, {31'd0, iREN}, 32'd1);
      chk({tag, "_busy_iaddr"}, iaddr, addr);
      chk({tag, "_busy_ihit"}, {31'd0, ihit}, 32'd0);
      tick();
    end
    iwait = 1'b0;
    iload = data;
    #1;
    chk({tag, "_done_iren"}, {31'd0, iREN}, 32'd1);
    chk({tag, "_done_iaddr"}, iaddr, addr);
    tick();
    iwait = 1'b1;
    iload = 32'hDEAD_BEEF;
  endtask

  task automatic do_miss(input string tag, input logic [31:0] addr, input logic [31:0] data, input int lat);
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    #1;
    chk({tag, "_miss_ihit"}, {31'd0, ihit}, 32'd0);
    chk({tag, "_miss_iren"}, {31'd0, iREN}, 32'd0);
    sb_q.push_back(data);
    tick();
    fill(tag, addr, data, lat);
    expect_hit(tag);
  endtask

  initial begin
    nRST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
    tick(); tick();
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_iren", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    nRST = 1'b0;

    // Reset state plus zero-latency fill of address 0.
    do_miss("cold0", 32'h0000_0000, 32'h1111_0000, 0);

    // Cold miss with L=3, then repeated hits.
    do_miss("cold40", 32'h0000_0040, 32'h8C01_0004, 3);
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(32'h8C01_0004);
      tick();
      expect_hit("rep40");
    end

    // Idle with no request: nothing happens.
    imemREN = 1'b0;
    #1;
    chk("idle_ihit", {31'd0, ihit}, 32'd0);
    tick();
    chk("idle_iren", {31'd0, iREN}, 32'd0);

    // Conflict eviction on index 1.
    do_miss("fill04", 32'h0000_0004, 32'hAAAA_0001, 1);
    do_miss("fill44", 32'h0000_0044, 32'hBBBB_0002, 2);
    do_miss("evict04", 32'h0000_0004, 32'hAAAA_0001, 0);

    // Address change mid-fill.
    imemREN = 1'b1; imemaddr = 32'h0000_0080;
    #1;
    chk("mid_miss_ihit", {31'd0, ihit}, 32'd0);
    sb_q.push_back(32'hCCCC_0080);
    tick();
    imemaddr = 32'h0000_0100;
    fill("mid80", 32'h0000_0080, 32'hCCCC_0080, 2);
    imemaddr = 32'h0000_0080;
    expect_hit("mid80_hit");
    imemaddr = 32'h0000_0100;
    #1;
    chk("mid100_ihit", {31'd0, ihit}, 32'd0);
    sb_q.push_back(32'hDDDD_0100);
    tick();
    fill("mid100", 32'h0000_0100, 32'hDDDD_0100, 0);
    expect_hit("mid100_hit");

    // Reset mid-fill while iwait=1.
    imemaddr = 32'h0000_0020;
    #1;
    chk("rstfill_ihit", {31'd0, ihit}, 32'd0);
    tick();
    chk("rstfill_iren", {31'd0, iREN}, 32'd1);
    nRST = 1'b1;
    tick();
    chk("rstfill_iren_after", {31'd0, iREN}, 32'd0);
    chk("rstfill_iaddr_after", iaddr, 32'd0);
    nRST = 1'b0;
    do_miss("refill20", 32'h0000_0020, 32'hEEEE_0020, 1);

    // Reset coinciding with fill completion: the write is dropped.
    imemaddr = 32'h0000_0028;
    #1;
    tick();
    iwait = 1'b0; iload = 32'h5555_0028; nRST = 1'b1;
    tick();
    chk("rstdone_iren", {31'd0, iREN}, 32'd0);
    nRST = 1'b0; iwait = 1'b1;
    do_miss("refill28", 32'h0000_0028, 32'h6666_0028, 0);

    // Byte offset is ignored.
    do_miss("fill10", 32'h0000_0010, 32'h1234_5678, 1);
    imemaddr = 32'h0000_0013;
    sb_q.push_back(32'h1234_5678);
    expect_hit("byte13");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
